// File: rtl/alu_cond_stage.sv
// Condition/writeback stage: evaluates the ARM condition against the NZCV register, updates flags, registers a gated writeback beat.
// Latency: one cycle; single output register with full throughput, in_ready = !out_valid || out_ready.
module alu_cond_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  input  logic [3:0]   cond,
  input  logic [1:0]   flag_write,
  input  logic         reg_write,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_write,
  output logic         out_cond_ex,
  output logic [3:0]   flags,
  output logic [15:0]  squash_count,
  input  logic         clr_stats
);

  logic         valid_q, valid_d;
  logic [N-1:0] result_q, result_d;
  logic         write_q, write_d;
  logic         cond_ex_q, cond_ex_d;
  logic [3:0]   flags_q, flags_d;
  logic [15:0]  squash_q, squash_d;

  logic accept;
  logic cond_ex;
  logic fn, fz, fc, fv;

  assign fn = flags_q[3];
  assign fz = flags_q[2];
  assign fc = flags_q[1];
  assign fv = flags_q[0];

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // The instruction's own alu_flags never feed its condition; only the architectural register does.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = fz;
      4'h1: cond_ex = !fz;
      4'h2: cond_ex = fc;
      4'h3: cond_ex = !fc;
      4'h4: cond_ex = fn;
      4'h5: cond_ex = !fn;
      4'h6: cond_ex = fv;
      4'h7: cond_ex = !fv;
      4'h8: cond_ex = fc && !fz;
      4'h9: cond_ex = !fc || fz;
      4'hA: cond_ex = (fn == fv);
      4'hB: cond_ex = (fn != fv);
      4'hC: cond_ex = !fz && (fn == fv);
      4'hD: cond_ex = fz || (fn != fv);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    write_d   = write_q;
    cond_ex_d = cond_ex_q;
    flags_d   = flags_q;
    squash_d  = squash_q;

    if (accept) begin
      valid_d   = 1'b1;
      result_d  = alu_result;
      write_d   = reg_write && cond_ex;
      cond_ex_d = cond_ex;
      if (cond_ex) begin
        if (flag_write[1]) flags_d[3:2] = alu_flags[3:2];
        if (flag_write[0]) flags_d[1:0] = alu_flags[1:0];
      end else if (squash_q != 16'hFFFF) begin
        squash_d = squash_q + 16'd1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    if (clr_stats) squash_d = 16'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      write_q   <= 1'b0;
      cond_ex_q <= 1'b0;
      flags_q   <= 4'b0000;
      squash_q  <= 16'd0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      write_q   <= write_d;
      cond_ex_q <= cond_ex_d;
      flags_q   <= flags_d;
      squash_q  <= squash_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_result   = result_q;
  assign out_write    = write_q;
  assign out_cond_ex  = cond_ex_q;
  assign flags        = flags_q;
  assign squash_count = squash_q;

endmodule

// File: tb/tb_alu_cond_stage.sv
// Bench for alu_cond_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_cond_stage;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] alu_result = '0;
  logic [3:0]   alu_flags = '0;
  logic [3:0]   cond = '0;
  logic [1:0]   flag_write = '0;
  logic         reg_write = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_result;
  logic         out_write;
  logic         out_cond_ex;
  logic [3:0]   flags;
  logic [15:0]  squash_count;
  logic         clr_stats = 1'b0;

  int chk_cnt = 0;
  int pass_cnt = 0;

  alu_cond_stage #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_flags(alu_flags), .cond(cond),
    .flag_write(flag_write), .reg_write(reg_write), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_write(out_write),
    .out_cond_ex(out_cond_ex), .flags(flags), .squash_count(squash_count),
    .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ARM pseudocode form: even codes select a base test, odd codes invert it.
  function automatic bit cond_pass(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0]) r = !r;
    return r;
  endfunction

  // Model state: what the outputs must show after each edge.
  bit          m_ov;
  logic [31:0] m_res;
  bit          m_wr, m_ce;
  logic [3:0]  m_flags;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov = 0; m_res = 0; m_wr = 0; m_ce = 0; m_flags = 0; m_cnt = 0;
    end else begin
      bit ce;
      if (in_valid && (!m_ov || out_ready)) begin
        ce = cond_pass(m_flags, cond);
        m_ov = 1; m_res = alu_result; m_wr = reg_write && ce; m_ce = ce;
        if (ce) begin
          if (flag_write[1]) m_flags[3:2] = alu_flags[3:2];
          if (flag_write[0]) m_flags[1:0] = alu_flags[1:0];
        end else if (m_cnt < 65535) begin
          m_cnt = m_cnt + 1;
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (clr_stats) m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("out_result", out_result, m_res);
        chk("out_write", 32'(out_write), 32'(m_wr));
        chk("out_cond_ex", 32'(out_cond_ex), 32'(m_ce));
      end
      chk("flags", 32'(flags), 32'(m_flags));
      chk("squash_count", 32'(squash_count), 32'(m_cnt));
      chk("in_ready", 32'(in_ready), 32'(!m_ov || out_ready));
    end
  end

  task automatic step(input bit v, input logic [31:0] res, input logic [3:0] af,
                      input logic [3:0] c, input logic [1:0] fw, input bit rw,
                      input bit ordy, input bit clr);
    in_valid = v; alu_result = res; alu_flags = af; cond = c;
    flag_write = fw; reg_write = rw; out_ready = ordy; clr_stats = clr;
    @(negedge clk); #1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 32'h0, 4'h0, 4'h0, 2'b00, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    logic [31:0] held_res;
    logic [3:0]  held_flags;

    #12 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_result", out_result, 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset squash", 32'(squash_count), 32'd0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("idle flags", 32'(flags), 32'd0);

    // Flag chain
    step(1, 32'h0, 4'b0100, 4'hE, 2'b11, 0, 1, 0);
    chk("chain flags", 32'(flags), 32'h4);
    step(1, 32'h1234, 4'b0000, 4'h0, 2'b00, 1, 1, 0);
    chk("chain eq write", 32'(out_write), 32'd1);
    chk("chain eq cond_ex", 32'(out_cond_ex), 32'd1);
    chk("chain eq result", out_result, 32'h1234);
    step(1, 32'h5678, 4'b0000, 4'h1, 2'b00, 1, 1, 0);
    chk("chain ne write", 32'(out_write), 32'd0);
    chk("chain ne squash", 32'(squash_count), 32'd1);

    // Partial update
    step(1, 32'h0, 4'b1111, 4'hE, 2'b11, 0, 1, 0);
    chk("partial all ones", 32'(flags), 32'hF);
    step(1, 32'h0, 4'b0000, 4'hE, 2'b10, 0, 1, 0);
    chk("partial nz only", 32'(flags), 32'h3);
    step(1, 32'h0, 4'b0000, 4'hA, 2'b11, 1, 1, 0);
    chk("ge squashed", 32'(out_cond_ex), 32'd0);
    chk("ge squash count", 32'(squash_count), 32'd2);
    chk("ge flags kept", 32'(flags), 32'h3);

    // Backpressure
    step(1, 32'hDEADBEEF, 4'b1000, 4'hE, 2'b11, 1, 1, 0);
    held_res = out_result;
    held_flags = flags;
    chk("bp loaded", held_res, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'hCAFEF00D, 4'b0101, 4'hE, 2'b11, 1, 0, 0);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp result hold", out_result, 32'hDEADBEEF);
      chk("bp flags hold", 32'(flags), 32'(held_flags));
    end
    step(1, 32'hCAFEF00D, 4'b0101, 4'hE, 2'b11, 1, 1, 0);
    chk("bp release load", out_result, 32'hCAFEF00D);
    chk("bp release valid", 32'(out_valid), 32'd1);
    chk("bp release flags", 32'(flags), 32'h5);

    // Saturation
    for (int i = 0; i < 65537; i++) step(1, i, 4'h0, 4'hF, 2'b11, 0, 1, 0);
    chk("sat count", 32'(squash_count), 32'hFFFF);
    step(1, 32'h0, 4'h0, 4'hF, 2'b11, 0, 1, 1);
    chk("clr priority", 32'(squash_count), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom, 4'($urandom), 4'($urandom),
           2'($urandom), 1'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 49) == 0);

    // Async reset mid-stall
    step(1, 32'h0, 4'b1010, 4'hE, 2'b11, 0, 1, 0);
    step(1, 32'h0, 4'h0, 4'hF, 2'b00, 0, 1, 0);
    step(1, 32'hABCD, 4'h0, 4'hE, 2'b00, 1, 0, 0);
    chk("stall pre valid", 32'(out_valid), 32'd1);
    chk("stall pre flags", 32'(flags), 32'hA);
    #2 rst_n = 1'b0;
    #1;
    chk("areset out_valid", 32'(out_valid), 32'd0);
    chk("areset flags", 32'(flags), 32'd0);
    chk("areset squash", 32'(squash_count), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b0);
    chk("post reset valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_cond_stage.md
# alu_cond_stage

Registered condition/writeback stage directly downstream of the ALU result/flag selector. It accepts the selected ALU result and its NZCV flags through a valid/ready handshake. It evaluates the instruction's ARM condition field against the architectural flag register, updates that register when the instruction executes and requests it, and presents a gated register-write result one cycle later. It also keeps a saturating count of squashed (condition-failed) instructions.

## Interface
Parameters:
- N, 32, datapath width of the ALU result

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream result/flags valid
- in_ready  out  1  stage can accept this cycle
- alu_result  in  N  selected ALU result
- alu_flags  in  4  selected ALU flags, [3]=N [2]=Z [1]=C [0]=V
- cond  in  4  ARM condition field of the instruction
- flag_write  in  2  [1] updates N,Z; [0] updates C,V
- reg_write  in  1  instruction wants to write its destination register
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output beat
- out_result  out  N  registered alu_result
- out_write  out  1  reg_write gated by condition pass
- out_cond_ex  out  1  condition passed for this beat
- flags  out  4  architectural NZCV register, same bit order as alu_flags
- squash_count  out  16  number of condition-failed instructions, saturating
- clr_stats  in  1  synchronous clear of squash_count

## Operation
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready, giving single-register pipeline behaviour with full throughput.
- The condition is evaluated combinationally against the current `flags` register value at the accept cycle. The incoming alu_flags are never used for the instruction's own condition.
- Condition codes, with cond_ex true when:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111 NV: 0
- On accept with cond_ex=1:
  - flags[3:2] <= alu_flags[3:2] if flag_write[1].
  - flags[1:0] <= alu_flags[1:0] if flag_write[0].
- On accept with cond_ex=0:
  - flags are unchanged.
  - squash_count increments, saturating at 16'hFFFF.
- On accept, the output register loads:
  - out_result <= alu_result (unconditionally)
  - out_write <= reg_write & cond_ex
  - out_cond_ex <= cond_ex
  - out_valid <= 1
- Squashed instructions still produce an output beat (out_valid=1, out_write=0) to keep program order.
- With no accept and out_ready=1, out_valid <= 0. The other output fields hold their last value.
- clr_stats has priority over an increment in the same cycle: the count goes to 0.

## Timing
- Reset (async assert, sync-released by the system) forces:
  - out_valid=0, out_result=0, out_write=0, out_cond_ex=0
  - flags=4'b0000, squash_count=0
- Latency: accept at edge k, output visible after edge k, consumed at the first edge where out_valid&&out_ready.
- Stall: while out_valid && !out_ready, all out_* hold stable and in_ready=0. No flag or counter change occurs.
- Back-to-back: an instruction accepted at edge k updates flags at edge k. The instruction accepted at edge k+1 sees the updated flags. No bubble is required.
- Simultaneous consume and accept (out_valid, out_ready, in_valid all high): the old beat leaves and the new beat loads in the same edge. out_valid stays 1.
- Reset mid-stall discards the held beat immediately, with no out_valid glitch after rst_n deasserts.

## Test plan
- Reset then idle:
  - All outputs are 0.
  - in_ready=1.
  - With in_valid=0 for 5 cycles, flags stay 0000.
- Flag chain: send three beats back-to-back with out_ready=1.
  - Beat 1: cond=AL, flag_write=11, alu_flags=0100.
  - Beat 2: cond=EQ, reg_write=1, result=32'h1234. Required: out_write=1, out_cond_ex=1.
  - Beat 3: cond=NE. Required: out_write=0, squash_count=1.
- Partial update:
  - flags=1111, then cond=AL, flag_write=10, alu_flags=0000. Required: flags=0011.
  - Then cond=GE with N=0, V=1. Required: squashed.
- Backpressure:
  - out_ready=0 for 4 cycles after a beat with result 32'hDEADBEEF.
  - Required: in_ready=0, and out_result and flags stable.
  - Then release with in_valid held: the next beat loads on the release edge.
- Saturation:
  - Force 65537 NV instructions. Required: squash_count=16'hFFFF.
  - Then clr_stats together with an NV accept. Required: squash_count=0.
- Async reset asserted mid-stall with out_valid=1. Required: out_valid, flags and squash_count are 0 immediately, without waiting for a clk edge.
